inst_trace_buffer: RTL

- Synthesizable instruction trace capture block. It sits beside the Processor core and snoops the fetched instruction word (inst31_0) on each valid cycle.
- Stores filtered instructions, each with a cycle timestamp, in a parametrised buffer.
- Supports stop-when-full and circular modes, plus an opcode trigger with post-trigger capture count.
- A valid/ready read port drains entries to a bench or debug link. It replaces ad-hoc $monitor printing of instructions.

---
 rtl/trace_pkg.sv | 38 +++
 rtl/trace_fifo_mem.sv | 90 +++++++++
 rtl/inst_trace_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the instruction trace buffer: FSM states, opcodes, entry layout.
// No logic here, so no latency.
// No backpressure here; types only.
package trace_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    // RV32 major opcodes commonly used as filter/trigger values
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Default entry widths; the buffer stores {inst, stamp} in this order
    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_STAMP_W = 16;

    typedef struct packed {
        logic [TRACE_DATA_W-1:0]  inst;
        logic [TRACE_STAMP_W-1:0] stamp;
    } trace_entry_t;

    // Masked opcode compare; a zero mask matches every opcode
    function automatic logic opc_match(input logic [6:0] opc,
                                       input logic [6:0] val,
                                       input logic [6:0] mask);
        return ((opc & mask) == (val & mask));
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Entry storage for the trace buffer: ring of DEPTH entries with show-ahead read.
// Write visible on rd_dat the cycle after the write edge; read data is combinational from the head.
// When full, a write is accepted only with a same-cycle pop or in wrap mode (overwrites oldest).
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wrap_mode,
    input  logic                     wr_req,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_req,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     wr_accept,
    output logic                     wr_lost
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_pop;
    logic overwrite;
    logic rd_adv;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rd_dat = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so full + pop never loses the write
    assign do_pop    = rd_req & ~empty;
    assign wr_accept = wr_req & (~full | do_pop | wrap_mode);
    assign wr_lost   = wr_req & full & ~do_pop;
    // Overwrite: the oldest entry is discarded by advancing the read side with the write
    assign overwrite = wr_accept & full & ~do_pop;
    assign rd_adv    = do_pop | overwrite;

    // Next pointers, count and storage contents
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                mem_d[wr_ptr_q] = wr_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(wr_accept) - CNT_W'(rd_adv);
        end
    end

    // State registers; reset discards all held entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/inst_trace_buffer.sv
// Instruction trace capture: filters fetched words, timestamps them, optional opcode trigger.
// Captured entry appears on rd_* right after its capture edge when the buffer was empty.
// rd_valid/rd_ready drain port; full buffer drops (stop mode) or overwrites oldest (wrap mode).
module inst_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
    parameter int POST_W  = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   inst_valid,
    input  logic [DATA_W-1:0]      inst31_0,
    input  logic                   arm,
    input  logic                   wrap_mode,
    input  logic [6:0]             filt_opcode,
    input  logic [6:0]             filt_mask,
    input  logic                   trig_en,
    input  logic [6:0]             trig_opcode,
    input  logic [POST_W-1:0]      post_cnt,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_inst,
    output logic [STAMP_W-1:0]     rd_stamp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   triggered,
    output logic                   done
);

    localparam int ENTRY_W = DATA_W + STAMP_W;

    trace_state_t        state_q, state_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [POST_W-1:0]   post_q, post_d;
    logic                triggered_q, triggered_d;
    logic                overflow_q, overflow_d;

    logic                filt_pass;
    logic                cap_req;
    logic                pop_req;
    logic                trig_hit;
    logic                wr_accept;
    logic                wr_lost;
    logic [ENTRY_W-1:0]  rd_entry;

    assign filt_pass = opc_match(inst31_0[6:0], filt_opcode, filt_mask);
    // Arm clears the buffer, so neither a capture nor a pop may land in the arm cycle
    assign cap_req   = inst_valid & filt_pass & ~arm &
                       ((state_q == ARMED) || (state_q == POST));
    assign pop_req   = rd_ready & ~arm;
    assign trig_hit  = trig_en & (inst31_0[6:0] == trig_opcode);

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk       (Clk),
        .rst_n     (Reset),
        .clear     (arm),
        .wrap_mode (wrap_mode),
        .wr_req    (cap_req),
        .wr_dat    ({inst31_0, stamp_q}),
        .rd_req    (pop_req),
        .rd_dat    (rd_entry),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .wr_accept (wr_accept),
        .wr_lost   (wr_lost)
    );

    assign rd_valid  = ~empty;
    assign rd_inst   = rd_entry[ENTRY_W-1:STAMP_W];
    assign rd_stamp  = rd_entry[STAMP_W-1:0];
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign done      = (state_q == DONE);

    // Next-state: arm dominates; only entries actually stored advance trigger/post logic
    always_comb begin
        state_d     = state_q;
        post_d      = post_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        stamp_d     = stamp_q + 1'b1;
        if (arm) begin
            state_d     = ARMED;
            post_d      = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (wr_lost) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                ARMED: begin
                    if (wr_accept && trig_hit) begin
                        triggered_d = 1'b1;
                        if (post_cnt == '0) begin
                            state_d = DONE;
                        end else begin
                            post_d  = post_cnt;
                            state_d = POST;
                        end
                    end
                end
                POST: begin
                    if (wr_accept) begin
                        post_d = post_q - 1'b1;
                        if (post_q == POST_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control and timestamp registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            stamp_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stamp_q     <= stamp_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
